// File: rtl/cram_backup_if.sv
// cram_backup_if: HPS SD sector-buffer handshake shared by the cart RAM
// backup streamer and the HPS side.
//   sd_lba       sector number requested by the streamer
//   sd_rd/sd_wr  sector read / write request
//   sd_ack       HPS acknowledge, high for the whole sector transfer
//   sd_buff_*    byte index, data and write strobe of the sector buffer
//   sd_buff_din  byte returned to the HPS on a save
// master = streamer (cram_backup), slave = HPS side.
interface cram_backup_if;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/cram_backup.sv
// cram_backup: battery-backed cart RAM streamer. Copies cart RAM to/from the
// HPS SD sector buffer in 512-byte sectors over the RAM's second port, and
// tracks a dirty flag from CPU writes.
// Ports:
//   clk_sys, reset_n     clock, asynchronous active-low reset
//   enable               cart loaded with battery; low forces IDLE
//   ram_mask             RAM size = (ram_mask+1) x 8 KB, latched per transfer
//   cram_wr              CPU cart RAM write strobe, sets dirty
//   bk_load, bk_save     start a load (SD->RAM) or save (RAM->SD)
//   bk_busy, bk_dirty    transfer in progress / RAM modified
//   sd                   SD sector-buffer handshake (master side)
//   bk_ram_addr/di/wr/do cart RAM port B (do has 1-cycle read latency)
module cram_backup (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [3:0]    ram_mask,
  input  logic          cram_wr,
  input  logic          bk_load,
  input  logic          bk_save,
  output logic          bk_busy,
  output logic          bk_dirty,
  cram_backup_if.master sd,
  output logic [16:0]   bk_ram_addr,
  output logic [7:0]    bk_ram_di,
  output logic          bk_ram_wr,
  input  logic [7:0]    bk_ram_do
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_NEXT = 2'd3;

  logic [1:0] state;
  logic [7:0] sector;
  logic [3:0] mask_q;
  logic       is_load;
  logic       dirty;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      sector  <= '0;
      mask_q  <= '0;
      is_load <= 1'b0;
      dirty   <= 1'b0;
    end else if (!enable) begin
      state  <= ST_IDLE;
      sector <= '0;
      dirty  <= 1'b0;
    end else begin
      if (cram_wr) dirty <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (bk_load || bk_save) begin
            // load wins a tie; acceptance clear overrides a same-cycle cram_wr
            is_load <= bk_load;
            sector  <= '0;
            mask_q  <= ram_mask;
            dirty   <= 1'b0;
            state   <= ST_REQ;
          end
        end
        ST_REQ:  if (sd.sd_ack) state <= ST_XFER;
        ST_XFER: if (!sd.sd_ack) state <= ST_NEXT;
        ST_NEXT: begin
          if (sector == {mask_q, 4'hF}) begin
            state <= ST_IDLE;
          end else begin
            sector <= sector + 8'd1;
            state  <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Requests decode straight from state so they drop the cycle after the
  // first sampled ack, and vanish asynchronously with reset.
  assign sd.sd_rd       = (state == ST_REQ) && is_load;
  assign sd.sd_wr       = (state == ST_REQ) && !is_load;
  assign sd.sd_lba      = {24'd0, sector};
  assign sd.sd_buff_din = bk_ram_do;

  assign bk_busy     = (state != ST_IDLE);
  assign bk_dirty    = dirty;
  assign bk_ram_addr = {sector, sd.sd_buff_addr};
  assign bk_ram_di   = sd.sd_buff_dout;
  assign bk_ram_wr   = sd.sd_buff_wr && (state == ST_XFER) && is_load;

endmodule

// File: tb/tb_cram_backup.sv
module tb_cram_backup;
  logic        clk_sys = 1'b0;
  logic        reset_n, enable, cram_wr, bk_load, bk_save;
  logic [3:0]  ram_mask;
  logic        bk_busy, bk_dirty, bk_ram_wr;
  logic [16:0] bk_ram_addr;
  logic [7:0]  bk_ram_di, bk_ram_do;

  cram_backup_if sd_if();

  cram_backup dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .enable      (enable),
    .ram_mask    (ram_mask),
    .cram_wr     (cram_wr),
    .bk_load     (bk_load),
    .bk_save     (bk_save),
    .bk_busy     (bk_busy),
    .bk_dirty    (bk_dirty),
    .sd          (sd_if),
    .bk_ram_addr (bk_ram_addr),
    .bk_ram_di   (bk_ram_di),
    .bk_ram_wr   (bk_ram_wr),
    .bk_ram_do   (bk_ram_do)
  );

  always #5 clk_sys = ~clk_sys;

  // Cart RAM port B (environment) and the expected RAM image.
  logic [7:0] cart_ram [0:131071];
  logic [7:0] exp_mem  [0:131071];
  always @(posedge clk_sys) begin
    if (bk_ram_wr) cart_ram[bk_ram_addr] <= bk_ram_di;
    bk_ram_do <= cart_ram[bk_ram_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int data_ctr = 0;
  int last_lba;
  logic [7:0] last_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start(input bit ld, input bit sv);
    bk_load = ld;
    bk_save = sv;
    tick();
    bk_load = 1'b0;
    bk_save = 1'b0;
    chk("start_busy", bk_busy, 1);
    chk("start_dirty", bk_dirty, 0);
    chk("start_rd", sd_if.sd_rd, ld);
    chk("start_wr", sd_if.sd_wr, !ld);
    chk("start_lba", sd_if.sd_lba, 0);
  endtask

  // HPS model: serves sectors until 'stop' or the end of the RAM, checking
  // the LBA sequence, request handshake and every byte against exp_mem.
  task automatic run_xfer(input bit ld, input bit full, input int mask,
                          input int wr_lba, input int stop);
    int n, nb, lim, proto, derr, waits, idx, bad;
    logic [8:0] a;
    logic [7:0] d;
    n = (mask + 1) * 16;
    nb = full ? 512 : 8;
    lim = (stop < n) ? stop : n;
    proto = 0;
    derr = 0;
    for (int s = 0; s < lim; s++) begin
      waits = 0;
      while (!(sd_if.sd_rd || sd_if.sd_wr) && waits < 8) begin tick(); waits++; end
      if (waits != ((s == 0) ? 0 : 1)) proto++;
      if (sd_if.sd_lba !== 32'(s)) proto++;
      if (sd_if.sd_rd !== ld || sd_if.sd_wr !== !ld) proto++;
      last_lba = int'(sd_if.sd_lba);
      sd_if.sd_ack = 1'b1;
      tick();
      if (sd_if.sd_rd || sd_if.sd_wr) proto++;
      for (int k = 0; k < nb; k++) begin
        if (full) a = 9'(k);
        else if (k == 0) a = 9'd0;
        else if (k == nb - 1) a = 9'h1FF;
        else a = 9'($urandom);
        idx = s * 512 + int'(a);
        cram_wr = (s == wr_lba && k == 2);
        sd_if.sd_buff_addr = a;
        if (ld) begin
          d = 8'(data_ctr);
          data_ctr++;
          sd_if.sd_buff_dout = d;
          sd_if.sd_buff_wr = 1'b1;
          #1;
          if (bk_ram_wr !== 1'b1 || bk_ram_di !== d || bk_ram_addr !== idx[16:0]) derr++;
          exp_mem[idx] = d;
          last_data = d;
          tick();
          cram_wr = 1'b0;
          sd_if.sd_buff_wr = 1'b0;
          tick();
        end else begin
          tick();
          cram_wr = 1'b0;
          if (sd_if.sd_buff_din !== exp_mem[idx] || bk_ram_wr !== 1'b0) derr++;
          if (full && s == 3 && a == 9'h1FF) chk("din_s3_1ff", sd_if.sd_buff_din, exp_mem[17'h07FF]);
          tick();
        end
      end
      sd_if.sd_ack = 1'b0;
      tick();
      if (bk_busy !== 1'b1) proto++;
      if (s == n - 1) begin
        tick();
        chk("busy_fall", bk_busy, 0);
      end
    end
    if (stop < n) begin
      waits = 0;
      while (!(sd_if.sd_rd || sd_if.sd_wr) && waits < 8) begin tick(); waits++; end
      chk("stop_lba", sd_if.sd_lba, stop);
    end
    chk("protocol", proto, 0);
    chk("byte_data", derr, 0);
    bad = 0;
    for (int i = 0; i < 131072; i++) if (cart_ram[i] !== exp_mem[i]) bad++;
    chk("ram_image", bad, 0);
  endtask

  typedef struct {
    logic en, cw, ld, sv;
    logic busy, rd, wr, dirty;
  } vec_t;
  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 131072; i++) begin
      cart_ram[i] = 8'($urandom);
      exp_mem[i] = cart_ram[i];
    end
    reset_n = 1'b0; enable = 1'b1; ram_mask = 4'd0;
    cram_wr = 1'b0; bk_load = 1'b0; bk_save = 1'b0;
    sd_if.sd_ack = 1'b0; sd_if.sd_buff_addr = '0;
    sd_if.sd_buff_dout = '0; sd_if.sd_buff_wr = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_busy", bk_busy, 0);
    chk("rst_dirty", bk_dirty, 0);
    chk("rst_rd", sd_if.sd_rd, 0);
    chk("rst_wr", sd_if.sd_wr, 0);
    chk("rst_lba", sd_if.sd_lba, 0);
    chk("rst_ram_wr", bk_ram_wr, 0);
    reset_n = 1'b1;
    tick();

    // Table: priority, ignored requests, dirty rules, enable drop
    for (int i = 0; i < 11; i++) begin
      enable = vecs[i].en; cram_wr = vecs[i].cw;
      bk_load = vecs[i].ld; bk_save = vecs[i].sv;
      tick();
      chk($sformatf("vec%0d_busy", i), bk_busy, vecs[i].busy);
      chk($sformatf("vec%0d_rd", i), sd_if.sd_rd, vecs[i].rd);
      chk($sformatf("vec%0d_wr", i), sd_if.sd_wr, vecs[i].wr);
      chk($sformatf("vec%0d_dirty", i), bk_dirty, vecs[i].dirty);
      chk($sformatf("vec%0d_lba", i), sd_if.sd_lba, 0);
    end
    enable = 1'b1; cram_wr = 1'b0; bk_load = 1'b0; bk_save = 1'b0;
    tick();

    // Full 8 KB save, CPU write in sector 2 re-dirties the image
    cram_wr = 1'b1; tick(); cram_wr = 1'b0;
    chk("dirty_set", bk_dirty, 1);
    start(1'b0, 1'b1);
    run_xfer(1'b0, 1'b1, 0, 2, 999);
    chk("dirty_after_save", bk_dirty, 1);

    // 128 KB load, mask changed after acceptance must not matter
    ram_mask = 4'hF;
    start(1'b1, 1'b0);
    ram_mask = 4'h2;
    run_xfer(1'b1, 1'b0, 15, -1, 999);
    chk("load_last_lba", last_lba, 255);
    chk("load_last_byte", cart_ram[17'h1FFFF], last_data);

    // bk_save during XFER ignored
    ram_mask = 4'd0;
    start(1'b1, 1'b0);
    sd_if.sd_ack = 1'b1; tick();
    bk_save = 1'b1; tick(); bk_save = 1'b0;
    sd_if.sd_ack = 1'b0; tick(); tick();
    chk("xfer_save_rd", sd_if.sd_rd, 1);
    chk("xfer_save_wr", sd_if.sd_wr, 0);
    chk("xfer_save_lba", sd_if.sd_lba, 1);
    enable = 1'b0; tick(); enable = 1'b1; tick();

    // enable drop at sector 5 in REQ, then restart from LBA 0
    start(1'b1, 1'b0);
    run_xfer(1'b1, 1'b0, 0, -1, 5);
    enable = 1'b0; tick();
    chk("endrop_busy", bk_busy, 0);
    chk("endrop_rd", sd_if.sd_rd, 0);
    chk("endrop_lba", sd_if.sd_lba, 0);
    enable = 1'b1;
    start(1'b1, 1'b0);
    run_xfer(1'b1, 1'b0, 0, -1, 999);

    // Randomized transfers
    for (int it = 0; it < 6; it++) begin
      int mask, wl;
      bit ld, both, pre;
      mask = int'($urandom_range(0, 1));
      ld = 1'($urandom);
      both = ld && 1'($urandom);
      pre = 1'($urandom);
      wl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, (mask + 1) * 16 - 1)) : -1;
      ram_mask = 4'(mask);
      if (pre) begin
        cram_wr = 1'b1; tick(); cram_wr = 1'b0;
        chk("rnd_pre_dirty", bk_dirty, 1);
      end
      start(ld, !ld || both);
      ram_mask = 4'($urandom);
      run_xfer(ld, 1'b0, mask, wl, 999);
      chk("rnd_dirty", bk_dirty, (wl >= 0) ? 1 : 0);
      chk("rnd_last_lba", last_lba, (mask + 1) * 16 - 1);
      tick();
    end

    // Asynchronous reset in REQ and mid-XFER
    ram_mask = 4'd0;
    start(1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_req_wr", sd_if.sd_wr, 0);
    chk("async_req_busy", bk_busy, 0);
    #1 reset_n = 1'b1;
    tick();
    start(1'b0, 1'b1);
    sd_if.sd_ack = 1'b1; tick();
    chk("xfer_busy", bk_busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_xfer_busy", bk_busy, 0);
    chk("async_xfer_wr", sd_if.sd_wr, 0);
    chk("async_xfer_lba", sd_if.sd_lba, 0);
    #1 reset_n = 1'b1;
    sd_if.sd_ack = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cram_backup.md
# cram_backup

Battery-backed cartridge RAM streamer sitting downstream of the active mapper (MBC1/3/5…), on the second port of the cart RAM. It copies cart RAM to and from the HPS SD sector interface in 512-byte sectors. The RAM size comes from the mapper's `ram_mask`, and the block tracks a dirty flag from CPU cart-RAM writes. During a transfer it raises `bk_busy` so the top level can pause the CPU.

## Interface
Parameters: none; sector size fixed at 512 bytes, bank size fixed at 8 KB.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `enable`  in  1  high when the cart is loaded and `has_battery` is set; low forces IDLE.
- `ram_mask`  in  4  from the mapper; RAM size = (`ram_mask`+1)×8 KB.
- `cram_wr`  in  1  CPU write strobe to cart RAM (already qualified by `ram_enabled`); sets dirty.
- `bk_load`  in  1  pulse: load RAM from SD.
- `bk_save`  in  1  pulse: save RAM to SD.
- `bk_busy`  out  1  transfer in progress.
- `bk_dirty`  out  1  RAM modified since last save/load start.
- `sd_lba`  out  32  sector number = {24'd0, sector}.
- `sd_rd`  out  1  sector read request.
- `sd_wr`  out  1  sector write request.
- `sd_ack`  in  1  HPS acknowledge; high for the whole sector transfer.
- `sd_buff_addr`  in  9  byte index within the sector.
- `sd_buff_dout`  in  8  byte from SD (load).
- `sd_buff_wr`  in  1  strobe for `sd_buff_dout`.
- `sd_buff_din`  out  8  byte to SD (save).
- `bk_ram_addr`  out  17  cart RAM port-B address.
- `bk_ram_di`  out  8  cart RAM write data.
- `bk_ram_wr`  out  1  cart RAM write strobe.
- `bk_ram_do`  in  8  cart RAM read data, 1-cycle synchronous latency.

## Operation
- State machine: IDLE, REQ, XFER, NEXT.
- IDLE: `bk_load` takes priority over `bk_save` when both are sampled high in the same cycle. Either one latches the direction, clears `sector` to 0, clears dirty and goes to REQ. Requests outside IDLE are ignored.
- REQ: drive `sd_rd` (load) or `sd_wr` (save) high. On the first cycle `sd_ack`=1 is sampled, drop the request and go to XFER.
- XFER: stay while `sd_ack`=1. On the falling edge of `sd_ack` go to NEXT.
- NEXT: if `sector` == {`ram_mask`,4'hF}, go to IDLE. Otherwise increment `sector` and go to REQ.
- `sector` is 8 bits and is compared against the mask latched at request start, so the last sector is 255 for a 128 KB RAM.
- Addressing: `bk_ram_addr` = {`sector`, `sd_buff_addr`}, combinational from the registered `sector`.
- Load path: `bk_ram_wr` = `sd_buff_wr` & XFER & load, and `bk_ram_di` = `sd_buff_dout`.
- Save path: `sd_buff_din` = `bk_ram_do`.
- `bk_busy` = (state != IDLE).
- Dirty flag: set by `cram_wr` in any state, cleared on request acceptance. If `cram_wr` and acceptance occur in the same cycle, the clear wins. The save snapshot semantics make that write belong to the new image.
- `enable` low in any state returns synchronously to IDLE and drops `sd_rd`/`sd_wr`. `sector` and the dirty flag are both cleared.

## Timing
- Reset values: state IDLE, `sector`=0, `bk_busy`=0, `bk_dirty`=0, `sd_rd`=0, `sd_wr`=0, `sd_lba`=0, `bk_ram_wr`=0.
- Acceptance: a request sampled at edge N puts `sd_rd`/`sd_wr` and `bk_busy` high after edge N. `sd_lba` is valid in the same cycle.
- Request deassertion: the request is low in the cycle after `sd_ack` is first sampled high.
- Save read latency: `sd_buff_din` corresponds to the `sd_buff_addr` presented one cycle earlier. The HPS holds the address for at least 2 cycles per byte.
- Sector gap: the sector after `sd_ack` falls is requested 2 cycles later (XFER→NEXT→REQ).
- Completion: `bk_busy` falls 2 cycles after the final `sd_ack` fall.
- Load writes are combinational pass-through with zero latency.
- Reset mid-transfer: outputs return to reset values immediately and asynchronously.

## Test plan
- Reset with `enable`=1: all outputs at reset values; assert `reset_n` mid-XFER → `sd_wr` and `bk_busy` drop without waiting for `clk_sys`.
- `ram_mask`=0, `bk_save` pulse, HPS model acks each sector for 1024 cycles: exactly 16 `sd_wr` pulses with `sd_lba` 0..15. `sd_buff_din` at sector 3, addr 0x1FF equals RAM[0x07FF]. `bk_busy` low 2 cycles after the 16th ack fall.
- `ram_mask`=4'hF, `bk_load` with incrementing SD data: 256 sectors read, `sd_lba` ends at 255, and RAM[0x1FFFF] is written with the last byte.
- `bk_load` and `bk_save` in the same cycle → `sd_rd`=1, `sd_wr`=0; a `bk_save` pulse during XFER is ignored.
- `cram_wr` → `bk_dirty`=1; `bk_save` accepted → `bk_dirty`=0; `cram_wr` during save → `bk_dirty`=1 after completion; `cram_wr` on the accept cycle → `bk_dirty` stays 0.
- `enable` drops at sector 5 in REQ → IDLE next cycle, `sd_rd`=0, `sector`=0; a new `bk_load` restarts at `sd_lba`=0.
